fmi_load_ctrl: RTL and testbench

FMI_LOAD_CTRL -- requirements
Module: fmi_load_ctrl

---
 rtl/fmi_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_fmi_load_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmi_load_ctrl.sv
// ============================================================================
//  Module      : fmi_load_ctrl
//  Description : Loads one TIX x TIY x TIF tile from external memory into the
//                FMI RAM as TIY*TIF single-row bursts of TIX words each.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmi_load_ctrl #(
    parameter int TIX        = 4,
    parameter int TIY        = 4,
    parameter int TIF        = 8,
    parameter int FMI_ADDR_W = 8,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    input  logic [15:0]           row_stride,
    input  logic [23:0]           plane_stride,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  fmi_we,
    output logic [FMI_ADDR_W-1:0] fmi_addr,
    output logic [DATA_W-1:0]     fmi_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int c_XW = (TIX > 1) ? $clog2(TIX) : 1;
    localparam int c_YW = (TIY > 1) ? $clog2(TIY) : 1;
    localparam int c_FW = (TIF > 1) ? $clog2(TIF) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [15:0]           r_row_stride;
    logic [23:0]           r_plane_stride;
    logic [31:0]           r_plane_acc;
    logic [31:0]           r_addr;
    logic [c_XW-1:0]       r_x;
    logic [c_YW-1:0]       r_y;
    logic [c_FW-1:0]       r_f;
    logic [FMI_ADDR_W-1:0] r_wr_addr;

    logic                  w_beat;
    logic                  w_row_end;
    logic                  w_col_end;
    logic                  w_plane_end;
    logic                  w_tile_end;
    logic [31:0]           w_rs;
    logic [31:0]           w_ps;

    assign w_beat      = (r_state == S_DATA) && mem_rvalid;
    assign w_row_end   = (r_x == c_XW'(TIX - 1));
    assign w_col_end   = (r_y == c_YW'(TIY - 1));
    assign w_plane_end = (r_f == c_FW'(TIF - 1));
    assign w_tile_end  = w_row_end && w_col_end && w_plane_end;
    assign w_rs        = {16'd0, r_row_stride};
    assign w_ps        = {8'd0, r_plane_stride};
    assign mem_addr    = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_REQ;
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_beat && w_row_end) w_next = w_tile_end ? S_FIN : S_REQ;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_addr always holds the start address of the next burst; it is built from
    // a plane accumulator plus running row offset so no multipliers are needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_stride   <= '0;
            r_plane_stride <= '0;
            r_plane_acc    <= '0;
            r_addr         <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_f            <= '0;
            r_wr_addr      <= '0;
            fmi_we         <= 1'b0;
            fmi_addr       <= '0;
            fmi_wdata      <= '0;
        end else begin
            fmi_we <= 1'b0;
            if ((r_state == S_IDLE) && start) begin
                r_row_stride   <= row_stride;
                r_plane_stride <= plane_stride;
                r_plane_acc    <= base_addr;
                r_addr         <= base_addr;
                r_x            <= '0;
                r_y            <= '0;
                r_f            <= '0;
                r_wr_addr      <= '0;
            end
            if (w_beat) begin
                fmi_we    <= 1'b1;
                fmi_addr  <= r_wr_addr;
                fmi_wdata <= mem_rdata;
                r_wr_addr <= r_wr_addr + FMI_ADDR_W'(1);
                if (w_row_end) begin
                    r_x <= '0;
                    if (w_col_end) begin
                        r_y         <= '0;
                        r_f         <= w_plane_end ? '0 : r_f + c_FW'(1);
                        r_plane_acc <= r_plane_acc + w_ps;
                        r_addr      <= r_plane_acc + w_ps;
                    end else begin
                        r_y    <= r_y + c_YW'(1);
                        r_addr <= r_addr + w_rs;
                    end
                end else begin
                    r_x <= r_x + c_XW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fmi_load_ctrl.sv
// ============================================================================
//  Module      : tb_fmi_load_ctrl
//  Description : Randomized self-checking bench for fmi_load_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmi_load_ctrl;

    localparam int TIX   = 4;
    localparam int TIY   = 4;
    localparam int TIF   = 8;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int TOTAL = TIX * TIY * TIF;
    localparam int NB    = TIY * TIF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   base_addr;
    logic [15:0]   row_stride;
    logic [23:0]   plane_stride;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          fmi_we;
    logic [AW-1:0] fmi_addr;
    logic [DW-1:0] fmi_wdata;
    logic          busy;
    logic          done;

    fmi_load_ctrl #(
        .TIX(TIX), .TIY(TIY), .TIF(TIF), .FMI_ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .row_stride(row_stride), .plane_stride(plane_stride),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fmi_we(fmi_we), .fmi_addr(fmi_addr), .fmi_wdata(fmi_wdata),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a load is TOTAL beats in bursts of TIX; a burst is
    // requested whenever every granted beat has arrived and beats remain.
    bit            m_active = 1'b0;
    int            m_granted = 0;
    int            m_beats = 0;
    bit            m_pend = 1'b0;
    int            m_pend_addr = 0;
    logic [DW-1:0] m_pend_data = '0;
    logic [31:0]   m_base = '0;
    logic [15:0]   m_rs = '0;
    logic [23:0]   m_ps = '0;
    int            w_cnt = 0;
    int            b_cnt = 0;
    int            d_cnt = 0;
    logic [31:0]   q_addr[$];
    bit            e_req;
    bit            e_done;
    bit            in_data;

    function automatic logic [31:0] burst_addr(input int k);
        logic [31:0] f;
        logic [31:0] y;
        f = 32'(k / TIY);
        y = 32'(k % TIY);
        return m_base + f * {8'd0, m_ps} + y * {16'd0, m_rs};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_done", done, 0);
            chk("rst_fmi_we", fmi_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_fmi_addr", fmi_addr, 0);
            chk("rst_fmi_wdata", fmi_wdata, 0);
            m_active = 1'b0;
            m_pend   = 1'b0;
        end else begin
            e_req   = m_active && (m_granted * TIX == m_beats) && (m_beats < TOTAL);
            e_done  = m_active && (m_beats == TOTAL);
            in_data = m_active && (m_granted * TIX > m_beats);
            chk("busy", busy, m_active);
            chk("mem_req", mem_req, e_req);
            chk("done", done, e_done);
            chk("fmi_we", fmi_we, m_pend);
            if (m_pend) begin
                chk("fmi_addr", fmi_addr, m_pend_addr);
                chk("fmi_wdata", fmi_wdata, m_pend_data);
            end
            if (e_req) chk("mem_addr", mem_addr, burst_addr(m_granted));
            if (fmi_we) w_cnt++;
            if (done) d_cnt++;
            m_pend = 1'b0;
            if (in_data && mem_rvalid) begin
                m_pend      = 1'b1;
                m_pend_addr = m_beats;
                m_pend_data = mem_rdata;
                m_beats++;
            end
            if (e_req && mem_gnt) begin
                q_addr.push_back(mem_addr);
                m_granted++;
                b_cnt++;
            end
            if (e_done) begin
                m_active = 1'b0;
            end else if (!m_active && start) begin
                m_active  = 1'b1;
                m_base    = base_addr;
                m_rs      = row_stride;
                m_ps      = plane_stride;
                m_granted = 0;
                m_beats   = 0;
                w_cnt     = 0;
                b_cnt     = 0;
                d_cnt     = 0;
                q_addr.delete();
            end
        end
    end

    // Memory-side responder: gnt mode 0 tied high, 1 after 5 wait cycles,
    // 2 random; rvalid mode 0 continuous, 1 random gaps (also during REQ).
    int gnt_mode = 0;
    int rv_mode  = 0;
    int req_wait = 0;

    always @(posedge clk) begin
        #1;
        mem_rdata  = DW'($urandom);
        mem_rvalid = (rv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        case (gnt_mode)
            0: mem_gnt = 1'b1;
            1: begin
                if (mem_req) begin
                    if (req_wait == 5) begin
                        mem_gnt  = 1'b1;
                        req_wait = 0;
                    end else begin
                        mem_gnt = 1'b0;
                        req_wait++;
                    end
                end else begin
                    mem_gnt  = 1'b0;
                    req_wait = 0;
                end
            end
            default: mem_gnt = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic run_load(input logic [31:0] b, input logic [15:0] rs, input logic [23:0] ps,
                            input int restart_at, input int reset_at, input bit start_in_fin);
        bit finished;
        bit restarted;
        finished  = 1'b0;
        restarted = 1'b0;
        @(posedge clk); #1;
        base_addr    = b;
        row_stride   = rs;
        plane_stride = ps;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5000 && !finished; c++) begin
            start = 1'b0;
            if (d_cnt > 0 && !m_active) begin
                finished = 1'b1;
            end else begin
                if (restart_at >= 0 && !restarted && m_granted == restart_at) begin
                    base_addr    = b + 32'h0055_5000;
                    row_stride   = rs + 16'd8;
                    plane_stride = ps + 24'd256;
                    start        = 1'b1;
                    restarted    = 1'b1;
                end
                if (start_in_fin && done) start = 1'b1;
                if (reset_at >= 0 && m_granted == reset_at &&
                    m_beats > (reset_at - 1) * TIX && m_beats < reset_at * TIX) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("async_busy", busy, 0);
                    chk("async_mem_req", mem_req, 0);
                    chk("async_fmi_we", fmi_we, 0);
                    chk("async_mem_addr", mem_addr, 0);
                    chk("async_fmi_addr", fmi_addr, 0);
                    chk("async_fmi_wdata", fmi_wdata, 0);
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                    repeat (3) @(posedge clk);
                    return;
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        chk("load_finished", finished, 1);
        chk("write_count", w_cnt, TOTAL);
        chk("burst_count", b_cnt, NB);
        chk("done_count", d_cnt, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        row_stride   = '0;
        plane_stride = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal, back-to-back grants and beats; start held into the done cycle.
        gnt_mode = 0; rv_mode = 0;
        run_load(32'h0000_1000, 16'd64, 24'd4096, -1, -1, 1'b1);
        if (q_addr.size() == NB) begin
            chk("lit_addr0", q_addr[0], 32'h0000_1000);
            chk("lit_addr1", q_addr[1], 32'h0000_1040);
            chk("lit_addr2", q_addr[2], 32'h0000_1080);
            chk("lit_addr3", q_addr[3], 32'h0000_10C0);
            chk("lit_addr4", q_addr[4], 32'h0000_2000);
            chk("lit_addr31", q_addr[31], 32'h0000_80C0);
        end else begin
            chk("lit_qsize", q_addr.size(), NB);
        end
        repeat (3) @(posedge clk);
        chk("idle_after_fin_start", busy, 0);

        // Delayed grant.
        gnt_mode = 1; rv_mode = 0;
        run_load(32'h0000_1000, 16'd64, 24'd4096, -1, -1, 1'b0);

        // Random grants and beat gaps, random configuration.
        gnt_mode = 2; rv_mode = 1;
        run_load($urandom, 16'($urandom), 24'($urandom), -1, -1, 1'b0);

        // Restart attempt at burst 10 must be ignored.
        gnt_mode = 0; rv_mode = 1;
        run_load(32'h0000_1000, 16'd64, 24'd4096, 10, -1, 1'b0);
        if (q_addr.size() == NB) chk("lit_restart_addr10", q_addr[10], 32'h0000_3080);
        else chk("restart_qsize", q_addr.size(), NB);

        // Reset in the middle of burst 7, then a clean load from base 0.
        gnt_mode = 0; rv_mode = 0;
        run_load(32'h0000_1000, 16'd64, 24'd4096, -1, 7, 1'b0);
        chk("post_reset_idle", busy, 0);
        rv_mode = 1;
        run_load(32'h0000_0000, 16'd64, 24'd4096, -1, -1, 1'b0);
        if (q_addr.size() == NB) chk("lit_base0_addr5", q_addr[5], 32'h0000_1040);
        else chk("base0_qsize", q_addr.size(), NB);

        // Address wrap at the top of the 32-bit space.
        gnt_mode = 1; rv_mode = 1;
        run_load(32'hFFFF_FFF0, 16'd16, 24'h000100, -1, -1, 1'b0);
        if (q_addr.size() == NB) begin
            chk("lit_wrap_addr0", q_addr[0], 32'hFFFF_FFF0);
            chk("lit_wrap_addr1", q_addr[1], 32'h0000_0000);
            chk("lit_wrap_addr4", q_addr[4], 32'h0000_00F0);
        end else begin
            chk("wrap_qsize", q_addr.size(), NB);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
